// File: rtl/jtgng_romarb_pkg.sv
// Shared types for the ROM arbiter: slot ids, FSM states and memory address width.
package jtgng_romarb_pkg;

  localparam int NSLOTS = 5;
  localparam int MEM_AW = 22;

  typedef enum logic [2:0] {
    ID_CHAR = 3'd0,
    ID_SCR  = 3'd1,
    ID_OBJ  = 3'd2,
    ID_MAIN = 3'd3,
    ID_SND  = 3'd4
  } slot_id_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  function automatic slot_id_t next_id(input slot_id_t id);
    return (id == ID_SND) ? ID_CHAR : slot_id_t'(id + 3'd1);
  endfunction

  function automatic logic [MEM_AW-1:0] region_addr(input logic [MEM_AW-1:0] offset,
                                                    input logic [MEM_AW-1:0] waddr);
    return offset + waddr;
  endfunction

endpackage

// File: rtl/jtgng_romarb_slot.sv
// One-entry ROM holding slot: combinational hit/ok, fetch-need flag, byte or word read-out.
// Latches its word address on grant and commits data plus that address on load.
module jtgng_romarb_slot
  import jtgng_romarb_pkg::*;
#(
  parameter int                AW     = 13,
  parameter bit                BYTE   = 1'b0,
  parameter logic [MEM_AW-1:0] OFFSET = '0,
  localparam int               DW     = BYTE ? 8 : 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_cs,
  input  logic [AW-1:0]     i_addr,
  input  logic              i_inflight,
  input  logic              i_grant,
  input  logic              i_load,
  input  logic [15:0]       i_din,
  output logic              o_ok,
  output logic              o_need,
  output logic [DW-1:0]     o_dout,
  output logic [MEM_AW-1:0] o_maddr
);

  localparam int WA = BYTE ? AW - 1 : AW;

  logic          r_valid;
  logic [WA-1:0] r_last_addr;
  logic [WA-1:0] r_pend_addr;
  logic [15:0]   r_data;
  logic [WA-1:0] w_waddr;
  logic          w_hit;

  // Byte slots drop addr[0] from the compare so a lane toggle stays a hit.
  generate
    if (BYTE) begin : g_byte
      assign w_waddr = i_addr[AW-1:1];
      assign o_dout  = i_addr[0] ? r_data[15:8] : r_data[7:0];
    end else begin : g_word
      assign w_waddr = i_addr;
      assign o_dout  = r_data;
    end
  endgenerate

  assign w_hit   = r_valid && (w_waddr == r_last_addr);
  assign o_ok    = i_cs && w_hit;
  assign o_need  = i_cs && !w_hit && !i_inflight;
  assign o_maddr = region_addr(OFFSET, MEM_AW'(w_waddr));

  // last_addr takes the address that was fetched, so a mid-flight change re-misses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid     <= 1'b0;
      r_last_addr <= '0;
      r_pend_addr <= '0;
      r_data      <= '0;
    end else begin
      if (i_grant) r_pend_addr <= w_waddr;
      if (i_load) begin
        r_data      <= i_din;
        r_last_addr <= r_pend_addr;
        r_valid     <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/jtgng_rom_arb.sv
// Five-client ROM arbiter onto one 16-bit memory port, one fetch outstanding, miss latency 3 cycles.
// JTGNG_ROMARB_RR_EN selects round-robin grant; otherwise fixed priority char>scr>obj>main>snd.
module jtgng_rom_arb
  import jtgng_romarb_pkg::*;
#(
  parameter logic [21:0] MAIN_OFFSET = 22'h00000,
  parameter logic [21:0] CHAR_OFFSET = 22'h0A000,
  parameter logic [21:0] SND_OFFSET  = 22'h0C000,
  parameter logic [21:0] SCR_OFFSET  = 22'h10000,
  parameter logic [21:0] OBJ_OFFSET  = 22'h20000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        main_cs,
  input  logic [16:0] main_addr,
  output logic [7:0]  main_dout,
  output logic        main_ok,
  input  logic        snd_cs,
  input  logic [14:0] snd_addr,
  output logic [7:0]  snd_dout,
  output logic        snd_ok,
  input  logic        char_cs,
  input  logic [12:0] char_addr,
  output logic [15:0] char_dout,
  output logic        char_ok,
  input  logic        scr_cs,
  input  logic [14:0] scr_addr,
  output logic [15:0] scr_dout,
  output logic        scr_ok,
  input  logic        obj_cs,
  input  logic [15:0] obj_addr,
  output logic [15:0] obj_dout,
  output logic        obj_ok,
  output logic [21:0] mem_addr,
  output logic        mem_rd,
  input  logic        mem_ack,
  input  logic        mem_rdy,
  input  logic [15:0] mem_din
);

  state_t            r_state, w_next;
  slot_id_t          r_cur, w_sel, w_idx, w_start;
  logic [MEM_AW-1:0] r_mem_addr;
  logic [NSLOTS-1:0] w_need, w_inflight, w_grant_vec, w_load_vec;
  logic [MEM_AW-1:0] w_maddr [NSLOTS];
  logic              w_found, w_grant, w_load;
`ifdef JTGNG_ROMARB_RR_EN
  slot_id_t          r_last;
`endif

  jtgng_romarb_slot #(.AW(13), .BYTE(1'b0), .OFFSET(CHAR_OFFSET)) u_char (
    .clk(clk), .rst(rst), .i_cs(char_cs), .i_addr(char_addr),
    .i_inflight(w_inflight[ID_CHAR]), .i_grant(w_grant_vec[ID_CHAR]), .i_load(w_load_vec[ID_CHAR]),
    .i_din(mem_din), .o_ok(char_ok), .o_need(w_need[ID_CHAR]), .o_dout(char_dout),
    .o_maddr(w_maddr[ID_CHAR]));

  jtgng_romarb_slot #(.AW(15), .BYTE(1'b0), .OFFSET(SCR_OFFSET)) u_scr (
    .clk(clk), .rst(rst), .i_cs(scr_cs), .i_addr(scr_addr),
    .i_inflight(w_inflight[ID_SCR]), .i_grant(w_grant_vec[ID_SCR]), .i_load(w_load_vec[ID_SCR]),
    .i_din(mem_din), .o_ok(scr_ok), .o_need(w_need[ID_SCR]), .o_dout(scr_dout),
    .o_maddr(w_maddr[ID_SCR]));

  jtgng_romarb_slot #(.AW(16), .BYTE(1'b0), .OFFSET(OBJ_OFFSET)) u_obj (
    .clk(clk), .rst(rst), .i_cs(obj_cs), .i_addr(obj_addr),
    .i_inflight(w_inflight[ID_OBJ]), .i_grant(w_grant_vec[ID_OBJ]), .i_load(w_load_vec[ID_OBJ]),
    .i_din(mem_din), .o_ok(obj_ok), .o_need(w_need[ID_OBJ]), .o_dout(obj_dout),
    .o_maddr(w_maddr[ID_OBJ]));

  jtgng_romarb_slot #(.AW(17), .BYTE(1'b1), .OFFSET(MAIN_OFFSET)) u_main (
    .clk(clk), .rst(rst), .i_cs(main_cs), .i_addr(main_addr),
    .i_inflight(w_inflight[ID_MAIN]), .i_grant(w_grant_vec[ID_MAIN]), .i_load(w_load_vec[ID_MAIN]),
    .i_din(mem_din), .o_ok(main_ok), .o_need(w_need[ID_MAIN]), .o_dout(main_dout),
    .o_maddr(w_maddr[ID_MAIN]));

  jtgng_romarb_slot #(.AW(15), .BYTE(1'b1), .OFFSET(SND_OFFSET)) u_snd (
    .clk(clk), .rst(rst), .i_cs(snd_cs), .i_addr(snd_addr),
    .i_inflight(w_inflight[ID_SND]), .i_grant(w_grant_vec[ID_SND]), .i_load(w_load_vec[ID_SND]),
    .i_din(mem_din), .o_ok(snd_ok), .o_need(w_need[ID_SND]), .o_dout(snd_dout),
    .o_maddr(w_maddr[ID_SND]));

`ifdef JTGNG_ROMARB_RR_EN
  assign w_start = next_id(r_last);
`else
  assign w_start = ID_CHAR;
`endif

  // First needing slot walking forward from w_start.
  always_comb begin
    w_found = 1'b0;
    w_sel   = ID_CHAR;
    w_idx   = w_start;
    for (int k = 0; k < NSLOTS; k++) begin
      if (!w_found && w_need[w_idx]) begin
        w_found = 1'b1;
        w_sel   = w_idx;
      end
      w_idx = next_id(w_idx);
    end
  end

  always_comb begin
    for (int i = 0; i < NSLOTS; i++) begin
      w_inflight[i]  = (r_state != ST_IDLE) && (r_cur == 3'(i));
      w_grant_vec[i] = w_grant && (w_sel == 3'(i));
      w_load_vec[i]  = w_load && (r_cur == 3'(i));
    end
  end

  always_comb begin
    w_next  = r_state;
    mem_rd  = 1'b0;
    w_grant = 1'b0;
    w_load  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_grant = 1'b1;
          w_next  = ST_REQ;
        end
      end
      ST_REQ: begin
        mem_rd = 1'b1;
        if (mem_ack) begin
          if (mem_rdy) begin
            w_load = 1'b1;
            w_next = ST_IDLE;
          end else begin
            w_next = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (mem_rdy) begin
          w_load = 1'b1;
          w_next = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_cur      <= ID_CHAR;
      r_mem_addr <= '0;
`ifdef JTGNG_ROMARB_RR_EN
      r_last     <= ID_SND;
`endif
    end else begin
      r_state <= w_next;
      if (w_grant) begin
        r_cur      <= w_sel;
        r_mem_addr <= w_maddr[w_sel];
`ifdef JTGNG_ROMARB_RR_EN
        r_last     <= w_sel;
`endif
      end
    end
  end

  assign mem_addr = r_mem_addr;

endmodule

// File: tb/tb_jtgng_rom_arb.sv
// Directed bench for jtgng_rom_arb: hand-driven memory handshake, constant expectations.
module tb_jtgng_rom_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        main_cs, snd_cs, char_cs, scr_cs, obj_cs;
  logic [16:0] main_addr;
  logic [14:0] snd_addr;
  logic [12:0] char_addr;
  logic [14:0] scr_addr;
  logic [15:0] obj_addr;
  logic [7:0]  main_dout, snd_dout;
  logic [15:0] char_dout, scr_dout, obj_dout;
  logic        main_ok, snd_ok, char_ok, scr_ok, obj_ok;
  logic [21:0] mem_addr;
  logic        mem_rd, mem_ack, mem_rdy;
  logic [15:0] mem_din;

  int checks   = 0;
  int failures = 0;

  jtgng_rom_arb dut (
    .clk(clk), .rst(rst),
    .main_cs(main_cs), .main_addr(main_addr), .main_dout(main_dout), .main_ok(main_ok),
    .snd_cs(snd_cs),   .snd_addr(snd_addr),   .snd_dout(snd_dout),   .snd_ok(snd_ok),
    .char_cs(char_cs), .char_addr(char_addr), .char_dout(char_dout), .char_ok(char_ok),
    .scr_cs(scr_cs),   .scr_addr(scr_addr),   .scr_dout(scr_dout),   .scr_ok(scr_ok),
    .obj_cs(obj_cs),   .obj_addr(obj_addr),   .obj_dout(obj_dout),   .obj_ok(obj_ok),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_ack(mem_ack), .mem_rdy(mem_rdy), .mem_din(mem_din)
  );

  always #5 clk = ~clk;

  task automatic wait_rd(output bit got);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (mem_rd === 1'b1) got = 1'b1;
    end
  endtask

  task automatic serve(input logic [15:0] d, output logic [21:0] a, output bit got);
    wait_rd(got);
    a = mem_addr;
    if (got) begin
      mem_ack = 1'b1;
      @(negedge clk);
      mem_ack = 1'b0;
      mem_rdy = 1'b1;
      mem_din = d;
      @(negedge clk);
      mem_rdy = 1'b0;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    main_addr = 17'h00001;
    char_cs   = 1'b1;
    #1;
    checks++; if (mem_rd !== 1'b0) begin failures++; $display("FAIL reset_mem_rd: got %0h want 0", mem_rd); end
    checks++; if (mem_addr !== 22'h0) begin failures++; $display("FAIL reset_mem_addr: got %06h want 000000", mem_addr); end
    checks++; if (char_ok !== 1'b0) begin failures++; $display("FAIL reset_char_ok: got %0h want 0", char_ok); end
    checks++; if (char_dout !== 16'h0) begin failures++; $display("FAIL reset_char_dout: got %04h want 0000", char_dout); end
    checks++; if (main_dout !== 8'h0) begin failures++; $display("FAIL reset_main_dout: got %02h want 00", main_dout); end
    checks++; if ({main_ok, snd_ok, scr_ok, obj_ok} !== 4'b0) begin failures++; $display("FAIL reset_ok_flags: got %04b want 0000", {main_ok, snd_ok, scr_ok, obj_ok}); end
    char_cs = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_char_miss;
    char_cs   = 1'b1;
    char_addr = 13'h0010;
    @(negedge clk);
    checks++; if (mem_rd !== 1'b1) begin failures++; $display("FAIL char_req_cycle1: got mem_rd=%0h want 1", mem_rd); end
    checks++; if (mem_addr !== 22'h0A010) begin failures++; $display("FAIL char_mem_addr: got %06h want 0A010", mem_addr); end
    checks++; if (char_ok !== 1'b0) begin failures++; $display("FAIL char_ok_in_req: got %0h want 0", char_ok); end
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    checks++; if (mem_rd !== 1'b0) begin failures++; $display("FAIL char_rd_dropped_in_wait: got %0h want 0", mem_rd); end
    mem_rdy = 1'b1;
    mem_din = 16'hBEEF;
    @(negedge clk);
    mem_rdy = 1'b0;
    checks++; if (char_ok !== 1'b1) begin failures++; $display("FAIL char_ok_cycle3: got %0h want 1", char_ok); end
    checks++; if (char_dout !== 16'hBEEF) begin failures++; $display("FAIL char_dout: got %04h want BEEF", char_dout); end
  endtask

  task automatic test_byte_select;
    logic [21:0] a;
    bit          got, seen;
    main_cs   = 1'b1;
    main_addr = 17'h00101;
    serve(16'h12AB, a, got);
    checks++; if (!got || a !== 22'h00080) begin failures++; $display("FAIL main_fetch_addr: got %06h (seen=%0d) want 000080", a, got); end
    checks++; if (main_ok !== 1'b1) begin failures++; $display("FAIL main_ok_after_fetch: got %0h want 1", main_ok); end
    checks++; if (main_dout !== 8'h12) begin failures++; $display("FAIL main_dout_hi: got %02h want 12", main_dout); end
    main_addr = 17'h00100;
    #1;
    checks++; if (main_dout !== 8'hAB) begin failures++; $display("FAIL main_dout_lo: got %02h want AB", main_dout); end
    checks++; if (main_ok !== 1'b1) begin failures++; $display("FAIL main_ok_lane_toggle: got %0h want 1", main_ok); end
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (mem_rd !== 1'b0) seen = 1'b1;
    end
    checks++; if (seen) begin failures++; $display("FAIL main_lane_no_fetch: got mem_rd=1 want 0"); end
  endtask

  task automatic test_priority;
    logic [21:0] exp_a [4];
    logic [21:0] a;
    bit          got;
`ifdef JTGNG_ROMARB_RR_EN
    exp_a = '{22'h0A020, 22'h10005, 22'h00100, 22'h0A030};
`else
    exp_a = '{22'h0A020, 22'h0A030, 22'h10005, 22'h00100};
`endif
    char_addr = 13'h0020;
    scr_cs    = 1'b1;
    scr_addr  = 15'h0005;
    main_addr = 17'h00200;
    for (int k = 0; k < 4; k++) begin
      serve(16'(16'h1111 * (k + 1)), a, got);
      checks++; if (!got || a !== exp_a[k]) begin failures++; $display("FAIL grant_order_%0d: got %06h (seen=%0d) want %06h", k, a, got, exp_a[k]); end
      if (k == 0) char_addr = 13'h0030;
    end
    checks++; if ({char_ok, scr_ok, main_ok} !== 3'b111) begin failures++; $display("FAIL prio_all_ok: got %03b want 111", {char_ok, scr_ok, main_ok}); end
`ifdef JTGNG_ROMARB_RR_EN
    checks++; if (char_dout !== 16'h4444 || scr_dout !== 16'h2222 || main_dout !== 8'h33) begin failures++; $display("FAIL prio_data: got %04h %04h %02h want 4444 2222 33", char_dout, scr_dout, main_dout); end
`else
    checks++; if (char_dout !== 16'h2222 || scr_dout !== 16'h3333 || main_dout !== 8'h44) begin failures++; $display("FAIL prio_data: got %04h %04h %02h want 2222 3333 44", char_dout, scr_dout, main_dout); end
`endif
  endtask

  task automatic test_obj_change;
    logic [21:0] a;
    bit          got;
    obj_cs   = 1'b1;
    obj_addr = 16'h0100;
    wait_rd(got);
    checks++; if (!got || mem_addr !== 22'h20100) begin failures++; $display("FAIL obj_first_addr: got %06h (seen=%0d) want 20100", mem_addr, got); end
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack  = 1'b0;
    obj_addr = 16'h0200;
    mem_rdy  = 1'b1;
    mem_din  = 16'h1111;
    @(negedge clk);
    mem_rdy = 1'b0;
    checks++; if (obj_ok !== 1'b0) begin failures++; $display("FAIL obj_ok_stale: got %0h want 0", obj_ok); end
    serve(16'h2222, a, got);
    checks++; if (!got || a !== 22'h20200) begin failures++; $display("FAIL obj_refetch_addr: got %06h (seen=%0d) want 20200", a, got); end
    checks++; if (obj_ok !== 1'b1 || obj_dout !== 16'h2222) begin failures++; $display("FAIL obj_refetch_data: got ok=%0h dout=%04h want ok=1 dout=2222", obj_ok, obj_dout); end
  endtask

  task automatic test_ack_rdy_same;
    bit got;
    scr_addr = 15'h0006;
    wait_rd(got);
    checks++; if (!got || mem_addr !== 22'h10006) begin failures++; $display("FAIL scr_same_cycle_addr: got %06h (seen=%0d) want 10006", mem_addr, got); end
    mem_ack = 1'b1;
    mem_rdy = 1'b1;
    mem_din = 16'h7777;
    @(negedge clk);
    mem_ack = 1'b0;
    mem_rdy = 1'b0;
    checks++; if (scr_ok !== 1'b1 || scr_dout !== 16'h7777) begin failures++; $display("FAIL scr_same_cycle_data: got ok=%0h dout=%04h want ok=1 dout=7777", scr_ok, scr_dout); end
    checks++; if (mem_rd !== 1'b0) begin failures++; $display("FAIL scr_same_cycle_idle: got mem_rd=%0h want 0", mem_rd); end
  endtask

  task automatic test_reset_mid;
    logic [21:0] a;
    bit          got, seen;
    snd_cs   = 1'b1;
    snd_addr = 15'h0004;
    wait_rd(got);
    checks++; if (!got || mem_addr !== 22'h0C002) begin failures++; $display("FAIL snd_addr: got %06h (seen=%0d) want 0C002", mem_addr, got); end
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    rst     = 1'b1;
    {main_cs, snd_cs, char_cs, scr_cs, obj_cs} = 5'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    mem_rdy = 1'b1;
    mem_din = 16'hDEAD;
    @(negedge clk);
    mem_rdy = 1'b0;
    checks++; if (mem_rd !== 1'b0) begin failures++; $display("FAIL rst_mid_mem_rd: got %0h want 0", mem_rd); end
    checks++; if ({main_ok, snd_ok, char_ok, scr_ok, obj_ok} !== 5'b0) begin failures++; $display("FAIL rst_mid_ok: got %05b want 00000", {main_ok, snd_ok, char_ok, scr_ok, obj_ok}); end
    checks++; if (snd_dout !== 8'h0 || char_dout !== 16'h0 || obj_dout !== 16'h0) begin failures++; $display("FAIL rst_mid_data: got %02h %04h %04h want 00 0000 0000", snd_dout, char_dout, obj_dout); end
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (mem_rd !== 1'b0) seen = 1'b1;
    end
    checks++; if (seen) begin failures++; $display("FAIL rst_mid_quiet: got mem_rd=1 want 0"); end
    snd_cs = 1'b1;
    serve(16'h5A3C, a, got);
    checks++; if (!got || a !== 22'h0C002) begin failures++; $display("FAIL snd_refetch_addr: got %06h (seen=%0d) want 0C002", a, got); end
    checks++; if (snd_ok !== 1'b1 || snd_dout !== 8'h3C) begin failures++; $display("FAIL snd_refetch_data: got ok=%0h dout=%02h want ok=1 dout=3C", snd_ok, snd_dout); end
  endtask

  task automatic test_cs_low;
    bit seen_rd, seen_ok;
    snd_cs  = 1'b0;
    seen_rd = 1'b0;
    seen_ok = 1'b0;
    for (int k = 0; k < 6; k++) begin
      snd_addr = 15'(k * 3 + 1);
      @(negedge clk);
      if (mem_rd !== 1'b0) seen_rd = 1'b1;
      if (snd_ok !== 1'b0) seen_ok = 1'b1;
    end
    checks++; if (seen_rd) begin failures++; $display("FAIL cs_low_no_fetch: got mem_rd=1 want 0"); end
    checks++; if (seen_ok) begin failures++; $display("FAIL cs_low_ok: got snd_ok=1 want 0"); end
    snd_addr = 15'h0005;
    #1;
    checks++; if (snd_dout !== 8'h5A || snd_ok !== 1'b0) begin failures++; $display("FAIL cs_low_retained: got dout=%02h ok=%0h want dout=5A ok=0", snd_dout, snd_ok); end
    snd_cs = 1'b1;
    #1;
    checks++; if (snd_ok !== 1'b1) begin failures++; $display("FAIL cs_high_hit: got %0h want 1", snd_ok); end
    @(negedge clk);
    checks++; if (mem_rd !== 1'b0) begin failures++; $display("FAIL cs_high_no_fetch: got mem_rd=%0h want 0", mem_rd); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    {main_cs, snd_cs, char_cs, scr_cs, obj_cs} = 5'b0;
    main_addr = '0; snd_addr = '0; char_addr = '0; scr_addr = '0; obj_addr = '0;
    mem_ack = 1'b0; mem_rdy = 1'b0; mem_din = '0;
    test_reset;
    test_char_miss;
    test_byte_select;
    test_priority;
    test_obj_change;
    test_ack_rdy_same;
    test_reset_mid;
    test_cs_low;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
